mio_bus_responder: RTL and testbench

//  Responder (memory/IO side) of the multicycle CPU's MemRead/MemWrite/CPU_MIO/MIO_ready bus.

---
 rtl/mio_pkg.sv | 19 +
 rtl/mio_counter.sv | 20 ++
 rtl/mio_bus_responder.sv | 135 +++++++++++++
 tb/tb_mio_bus_responder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mio_pkg.sv
// Shared definitions for the MIO bus responder: address regions, FSM states
// and the bus-request qualifier.
package mio_pkg;

  localparam logic [3:0] REG_RAM  = 4'h0;
  localparam logic [3:0] REG_GPIO = 4'hE;
  localparam logic [3:0] REG_CNT  = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  function automatic logic is_req(input logic mio, input logic rd, input logic wr);
    return mio & (rd | wr);
  endfunction

endpackage

// File: rtl/mio_counter.sv
// Free-running 32-bit counter; a synchronous load takes priority over the increment.
module mio_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld,
  input  logic [31:0] d,
  output logic [31:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 32'd0;
    end else if (ld) begin
      q <= d;
    end else begin
      q <= q + 32'd1;
    end
  end

endmodule

// File: rtl/mio_bus_responder.sv
// Memory/IO side of the CPU MemRead/MemWrite/CPU_MIO/MIO_ready bus: decodes
// RAM, GPIO and counter regions, inserts RAM wait states, pulses MIO_ready once.
module mio_bus_responder
  import mio_pkg::*;
#(
  parameter int RAM_AW   = 10,
  parameter int RAM_WAIT = 2,
  parameter int GPIO_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              CPU_MIO,
  input  logic [31:0]       addr_bus,
  input  logic [31:0]       Data_out,
  output logic [31:0]       Data_in,
  output logic              MIO_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout,
  output logic [GPIO_W-1:0] led_out,
  input  logic [GPIO_W-1:0] sw_in
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [3:0]  r_wcnt;
  logic [3:0]  w_wcnt_nxt;
  logic [3:0]  r_region;
  logic        r_wr;
  logic        w_req;
  logic        w_idle_req;
  logic        w_is_wr;
  logic [3:0]  w_region;
  logic [31:0] w_io_rdata;
  logic [31:0] w_cnt_q;
  logic        w_cnt_ld;
  logic        w_unused_addr;

  // Both MemRead and MemWrite high counts as a write.
  assign w_req         = is_req(CPU_MIO, MemRead, MemWrite);
  assign w_idle_req    = (r_state == S_IDLE) && w_req;
  assign w_region      = addr_bus[31:28];
  assign w_is_wr       = MemWrite;
  assign w_cnt_ld      = w_idle_req && w_is_wr && (w_region == REG_CNT);
  assign w_unused_addr = ^{addr_bus[27:RAM_AW+2], addr_bus[1:0]};

  mio_counter u_counter (
    .clk   (clk),
    .reset (reset),
    .ld    (w_cnt_ld),
    .d     (Data_out),
    .q     (w_cnt_q)
  );

  always_comb begin
    w_io_rdata = 32'd0;
    case (w_region)
      REG_GPIO: w_io_rdata = 32'(sw_in);
      REG_CNT:  w_io_rdata = w_cnt_q;
      default:  w_io_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_wcnt  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_region == REG_RAM) begin
            w_state_nxt = S_WAIT;
            w_wcnt_nxt  = 4'(RAM_WAIT - 1);
          end else begin
            w_state_nxt = S_ACK;
          end
        end
      end
      S_WAIT: begin
        if (r_wcnt == 4'd0) begin
          w_state_nxt = S_ACK;
        end else begin
          w_wcnt_nxt = r_wcnt - 4'd1;
        end
      end
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ram_we is raised only on entry to WAIT, so it lives for the first WAIT cycle alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      MIO_ready <= 1'b0;
      ram_we    <= 1'b0;
      Data_in   <= 32'd0;
      led_out   <= '0;
      ram_addr  <= '0;
      ram_din   <= 32'd0;
      r_region  <= REG_RAM;
      r_wr      <= 1'b0;
    end else begin
      MIO_ready <= (w_state_nxt == S_ACK);
      ram_we    <= w_idle_req && w_is_wr && (w_region == REG_RAM);
      if (w_idle_req) begin
        r_region <= w_region;
        r_wr     <= w_is_wr;
        ram_addr <= addr_bus[RAM_AW+1:2];
        ram_din  <= Data_out;
        if (w_region != REG_RAM) begin
          if (!w_is_wr) begin
            Data_in <= w_io_rdata;
          end else if (w_region == REG_GPIO) begin
            led_out <= Data_out[GPIO_W-1:0];
          end
        end
      end else if ((r_state == S_WAIT) && (r_wcnt == 4'd0) && !r_wr && (r_region == REG_RAM)) begin
        Data_in <= ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_mio_bus_responder.sv
// Randomised and directed bench for mio_bus_responder against a transaction-level model.
module tb_mio_bus_responder;

  localparam int RAM_AW   = 10;
  localparam int RAM_WAIT = 2;
  localparam int GPIO_W   = 16;

  logic              clk;
  logic              reset;
  logic              MemRead;
  logic              MemWrite;
  logic              CPU_MIO;
  logic [31:0]       addr_bus;
  logic [31:0]       Data_out;
  logic [31:0]       Data_in;
  logic              MIO_ready;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic              ram_we;
  logic [31:0]       ram_dout;
  logic [GPIO_W-1:0] led_out;
  logic [GPIO_W-1:0] sw_in;

  mio_bus_responder #(.RAM_AW(RAM_AW), .RAM_WAIT(RAM_WAIT), .GPIO_W(GPIO_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .CPU_MIO   (CPU_MIO),
    .addr_bus  (addr_bus),
    .Data_out  (Data_out),
    .Data_in   (Data_in),
    .MIO_ready (MIO_ready),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .ram_dout  (ram_dout),
    .led_out   (led_out),
    .sw_in     (sw_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board RAM: synchronous read, data one cycle after the address.
  logic [31:0] mem [0:(1<<RAM_AW)-1];
  initial begin
    for (int i = 0; i < (1 << RAM_AW); i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[5] = 32'hDEADBEEF;
    forever begin
      @(posedge clk);
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  int          cyc = 0;
  int          rdy_cnt = 0;
  int          we_cnt = 0;
  logic [31:0] we_addr = 32'd0;
  logic [31:0] we_data = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (MIO_ready) rdy_cnt <= rdy_cnt + 1;
    if (ram_we) begin
      we_cnt  <= we_cnt + 1;
      we_addr <= 32'(ram_addr);
      we_data <= ram_din;
    end
  end

  // Reference model state
  logic [31:0]       ref_mem [0:(1<<RAM_AW)-1];
  logic [31:0]       ref_din;
  logic [GPIO_W-1:0] ref_led;
  logic [31:0]       cnt_base;
  int                cnt_at;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Entered and left #1 after a posedge with the responder idle.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int pre_idle, input string tag);
    int          s;
    int          lat;
    int          rdy0;
    int          we0;
    int          word;
    int          exp_lat;
    logic [3:0]  rg;
    logic [31:0] exp_din;
    repeat (pre_idle) begin
      @(posedge clk);
      #1;
    end
    s       = cyc + 1;
    rg      = addr[31:28];
    word    = int'(addr[RAM_AW+1:2]);
    exp_lat = (rg == 4'h0) ? RAM_WAIT + 1 : 1;
    exp_din = ref_din;
    if (!wr) begin
      case (rg)
        4'h0:    exp_din = ref_mem[word];
        4'hE:    exp_din = 32'(sw_in);
        4'hF:    exp_din = cnt_base + 32'(s - 1 - cnt_at);
        default: exp_din = 32'h0;
      endcase
    end
    rdy0     = rdy_cnt;
    we0      = we_cnt;
    CPU_MIO  = 1'b1;
    MemRead  = rd;
    MemWrite = wr;
    addr_bus = addr;
    Data_out = wdata;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!MIO_ready && lat < 40);
    chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "/data_in"}, Data_in, exp_din);
    @(posedge clk);
    #1;
    CPU_MIO  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    addr_bus = $urandom;
    Data_out = $urandom;
    chk({tag, "/ready_pulses"}, 32'(rdy_cnt - rdy0), 32'd1);
    chk({tag, "/ready_low"}, 32'(MIO_ready), 32'd0);
    if (wr) begin
      case (rg)
        4'h0: begin
          ref_mem[word] = wdata;
          chk({tag, "/we_pulses"}, 32'(we_cnt - we0), 32'd1);
          chk({tag, "/we_addr"}, we_addr, 32'(word));
          chk({tag, "/we_data"}, we_data, wdata);
        end
        4'hE: ref_led = wdata[GPIO_W-1:0];
        4'hF: begin
          cnt_base = wdata;
          cnt_at   = s;
        end
        default: ;
      endcase
    end else begin
      ref_din = exp_din;
    end
    if (!(wr && rg == 4'h0)) chk({tag, "/we_none"}, 32'(we_cnt - we0), 32'd0);
    chk({tag, "/led_out"}, 32'(led_out), 32'(ref_led));
  endtask

  initial begin
    logic [31:0] a;
    int          k;
    int          m;
    int          r0;
    int          w0;
    for (int i = 0; i < (1 << RAM_AW); i++) ref_mem[i] = 32'hA000_0000 | 32'(i);
    ref_mem[5] = 32'hDEADBEEF;
    ref_din  = 32'd0;
    ref_led  = '0;
    cnt_base = 32'd0;
    cnt_at   = 0;
    reset    = 1'b1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    CPU_MIO  = 1'b0;
    addr_bus = 32'd0;
    Data_out = 32'd0;
    sw_in    = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst/data_in", Data_in, 32'd0);
    chk("rst/ready", 32'(MIO_ready), 32'd0);
    chk("rst/ram_we", 32'(ram_we), 32'd0);
    chk("rst/led_out", 32'(led_out), 32'd0);
    chk("rst/ram_addr", 32'(ram_addr), 32'd0);
    chk("rst/ram_din", ram_din, 32'd0);
    reset  = 1'b0;
    cnt_at = cyc;

    access(1'b1, 1'b0, 32'hF000_0000, 32'd0, 0, "cnt_after_rst");

    access(1'b1, 1'b0, 32'h0000_0014, 32'd0, 0, "ram_rd5");
    chk("ram_rd5/const", Data_in, 32'hDEADBEEF);

    access(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 0, "ram_wr8");
    chk("ram_wr8/addr_const", we_addr, 32'd8);
    access(1'b1, 1'b0, 32'h0000_0020, 32'd0, 1, "ram_rd8");
    chk("ram_rd8/const", Data_in, 32'h1234_5678);

    access(1'b0, 1'b1, 32'hE000_0000, 32'h0000_A5A5, 0, "gpio_wr");
    chk("gpio_wr/const", 32'(led_out), 32'h0000_A5A5);
    sw_in = 16'h00FF;
    access(1'b1, 1'b0, 32'hE000_0000, 32'd0, 0, "gpio_rd");
    chk("gpio_rd/const", Data_in, 32'h0000_00FF);

    access(1'b0, 1'b1, 32'hF000_0000, 32'hFFFF_FFFE, 0, "cnt_wr");
    access(1'b1, 1'b0, 32'hF000_0000, 32'd0, 2, "cnt_rd");
    chk("cnt_rd/wrap_const", Data_in, 32'h0000_0001);

    access(1'b1, 1'b0, 32'h5000_0000, 32'd0, 0, "unmapped_rd");
    chk("unmapped_rd/const", Data_in, 32'd0);
    r0 = rdy_cnt;
    repeat (3) @(posedge clk);
    #1;
    chk("unmapped_rd/no_extra_ready", 32'(rdy_cnt - r0), 32'd0);
    access(1'b1, 1'b1, 32'h0000_0030, 32'hCAFE_F00D, 0, "both_is_write");
    access(1'b1, 1'b0, 32'h0000_0030, 32'd0, 0, "both_readback");

    // Reset during the WAIT of a RAM read.
    r0 = rdy_cnt;
    w0 = we_cnt;
    CPU_MIO  = 1'b1;
    MemRead  = 1'b1;
    addr_bus = 32'h0000_0014;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst/ready", 32'(MIO_ready), 32'd0);
    chk("midrst/data_in", Data_in, 32'd0);
    chk("midrst/ram_we", 32'(ram_we), 32'd0);
    chk("midrst/led_out", 32'(led_out), 32'd0);
    reset    = 1'b0;
    CPU_MIO  = 1'b0;
    MemRead  = 1'b0;
    ref_din  = 32'd0;
    ref_led  = '0;
    cnt_base = 32'd0;
    cnt_at   = cyc;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst/no_ready", 32'(rdy_cnt - r0), 32'd0);
    chk("midrst/no_we", 32'(we_cnt - w0), 32'd0);
    access(1'b1, 1'b0, 32'h0000_0020, 32'd0, 0, "post_rst_rd");

    for (int i = 0; i < 80; i++) begin
      k = int'($urandom_range(0, 3));
      case (k)
        0:       a = {4'h0, 16'($urandom), 6'd0, 4'($urandom), 2'($urandom)};
        1:       a = {4'hE, 28'($urandom)};
        2:       a = {4'hF, 28'($urandom)};
        default: a = {4'($urandom_range(1, 13)), 28'($urandom)};
      endcase
      m     = int'($urandom_range(0, 4));
      sw_in = 16'($urandom);
      access((m <= 1) || (m == 4), (m >= 2), a, $urandom, int'($urandom_range(0, 2)), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
